axis_trigger_capture: RTL and testbench
=======================================

# axis_trigger_capture

Triggered capture gate for the acquisition path: forwards an ADC sample stream to a RAM writer only while armed. It guarantees a minimum number of pre-trigger samples before a trigger is accepted, then ends the capture after a programmed number of post-trigger samples. It sits between the sample source and the DMA/RAM writer, consumes the trigger flag produced by the trigger detector, and reports the trigger position for readout.

## Interface
- AXIS_TDATA_WIDTH, 32, sample width
- CNTR_WIDTH, 16, width of length configuration, counters and trigger position
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  synchronous reset, active-high
- run_flag  in  1  a rising edge arms one capture
- trg_flag  in  1  trigger qualifier for the current input sample; already gated with s_axis_tvalid upstream
- pre_data  in  CNTR_WIDTH  pre-trigger sample count
- tot_data  in  CNTR_WIDTH  total capture length, pre plus post
- sts_data  out  CNTR_WIDTH  sample index of the last accepted trigger
- busy  out  1  capture in progress
- s_axis_tready  out  1  input ready
- s_axis_tdata  in  AXIS_TDATA_WIDTH  input sample
- s_axis_tvalid  in  1  input valid
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  AXIS_TDATA_WIDTH  output sample, equal to s_axis_tdata
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  marks the final sample of a capture

## Operation
- Transfer: a cycle with s_axis_tvalid & s_axis_tready.
- States: IDLE, PRE, WAIT, POST.
  - IDLE: s_axis_tready=1, so samples are discarded. m_axis_tvalid=0. busy=0.
  - PRE, WAIT, POST: s_axis_tready=m_axis_tready, m_axis_tvalid=s_axis_tvalid, m_axis_tdata=s_axis_tdata (combinational). busy=1.
- Arming:
  - run_prev is a register of run_flag. An arm event is run_flag & ~run_prev.
  - In IDLE, an arm event clears idx_cnt and pre_cnt, latches pre_len=pre_data and tot_len=tot_data, and moves to PRE. If pre_data==0 it moves to WAIT instead.
  - Arm events outside IDLE are ignored.
- idx_cnt increments on every transfer outside IDLE and wraps modulo 2^CNTR_WIDTH.
- PRE: pre_cnt increments per transfer. The transfer that makes pre_cnt==pre_len moves the block to WAIT. trg_flag is ignored in PRE.
- WAIT: the trigger is accepted on a transfer with trg_flag=1.
  - On accept: sts_data <= idx_cnt, the index of that sample (first forwarded sample = 0), and post_cnt <= 1.
  - post_len = tot_len - pre_len if tot_len > pre_len, else 1.
  - If post_len==1, the trigger sample carries tlast and the next state is IDLE. Otherwise the next state is POST.
- POST: post_cnt increments per transfer. m_axis_tlast=1 when post_cnt==post_len-1. The transfer carrying tlast returns the block to IDLE.
- m_axis_tlast is 0 in all other cases and is never asserted outside a transfer-capable state.
- The subtraction for post_len is unsigned and CNTR_WIDTH bits wide. The tot_len <= pre_len case is clamped as above; it never underflows.
- sts_data holds its value until the next accepted trigger. Arming does not clear it.

## Timing
- Reset values: state IDLE, busy=0, m_axis_tvalid=0, m_axis_tlast=0, s_axis_tready=1, sts_data=0, all counters 0, run_prev=0.
- Because run_prev resets to 0, a run_flag held high through reset arms the block on the first cycle after release.
- Arm latency: for a run_flag edge at cycle N (run_flag high at N, low at N-1), the state changes at N+1. The sample present at N+1 is the first one eligible for forwarding, and busy=1 from N+1.
- Zero-latency datapath: tdata, tvalid, tready and tlast are combinational from the current state and counters.
- Back-pressure: while m_axis_tready=0 in a capture state, no transfer occurs and no counter advances. A trg_flag in such a cycle is ignored.
- Simultaneous events: a trigger on the same transfer that completes PRE is not accepted. The first transfer in WAIT is the earliest possible trigger.
- The return to IDLE takes effect the cycle after the tlast transfer. An arm event in that tlast cycle is ignored; an arm event one cycle later is honoured.
- areset mid-capture aborts immediately: next cycle is in IDLE, no tlast is emitted, and sts_data is reset to 0.

## Test plan
- pre_data=4, tot_data=10, m_axis_tready=1, continuous valid, trg_flag at 7th forwarded sample → sts_data=6. Exactly 10... no: 7 + 5 post-trigger samples forwarded (trigger plus 5 further, post_len=6 ends at idx 11). tlast on idx 11. busy falls the next cycle.
- Same configuration, trg_flag pulsed on idx 2 and idx 3 (during PRE) and again on idx 4 → triggers in PRE are ignored; trigger accepted with sts_data=4.
- pre_data=0, tot_data=1, trg_flag on the first sample → that sample is forwarded with tlast. sts_data=0. Back to IDLE one cycle later.
- tot_data=3, pre_data=5 (clamp case) → only the trigger sample is forwarded after PRE, and it carries tlast.
- m_axis_tready toggled every cycle during POST → output sample count and tlast position are identical to the stall-free run. No sample is forwarded with tready=0.
- areset asserted mid-POST, then run_flag re-pulsed → no tlast is seen. busy=0 after reset. A new capture restarts with idx 0.

Source files
------------

// File: rtl/axis_trigger_capture_if.sv
// AXI4-Stream bundle for the trigger capture gate.
// The slave view omits tlast because the sample source never marks packet ends.
interface axis_trigger_capture_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_trigger_capture.sv
// Triggered capture gate: after an arm edge, forwards a guaranteed pre-trigger window,
// waits for a trigger, then forwards the post-trigger tail and closes the capture with tlast.
module axis_trigger_capture #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  run_flag,
    input  logic                  trg_flag,
    input  logic [CNTR_WIDTH-1:0] pre_data,
    input  logic [CNTR_WIDTH-1:0] tot_data,
    output logic [CNTR_WIDTH-1:0] sts_data,
    output logic                  busy,
    axis_trigger_capture_if.slave  s_axis,
    axis_trigger_capture_if.master m_axis
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_WAIT,
        S_POST
    } state_t;

    state_t                state_q, state_d;
    logic                  run_prev_q;
    logic [CNTR_WIDTH-1:0] idx_cnt_q, idx_cnt_d;
    logic [CNTR_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNTR_WIDTH-1:0] post_cnt_q, post_cnt_d;
    logic [CNTR_WIDTH-1:0] pre_len_q, pre_len_d;
    logic [CNTR_WIDTH-1:0] tot_len_q, tot_len_d;
    logic [CNTR_WIDTH-1:0] sts_q, sts_d;

    logic                        arm;
    logic                        xfer;
    logic [CNTR_WIDTH-1:0]       post_len;
    logic [CNTR_WIDTH-1:0]       pre_cnt_inc;
    logic                        s_tready;
    logic                        m_tvalid;
    logic                        m_tlast;
    logic                        busy_c;
    logic [AXIS_TDATA_WIDTH-1:0] sample;

    assign arm         = run_flag & ~run_prev_q;
    assign xfer        = s_axis.tvalid & m_axis.tready;
    assign pre_cnt_inc = pre_cnt_q + 1'b1;
    // Clamp the tail to the trigger sample alone when the total does not exceed the pre window.
    assign post_len    = (tot_len_q > pre_len_q) ? (tot_len_q - pre_len_q) : CNTR_WIDTH'(1);

    // NOTE: sequential state uses <= only, so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= S_IDLE;
            run_prev_q <= 1'b0;
            idx_cnt_q  <= '0;
            pre_cnt_q  <= '0;
            post_cnt_q <= '0;
            pre_len_q  <= '0;
            tot_len_q  <= '0;
            sts_q      <= '0;
        end else begin
            state_q    <= state_d;
            run_prev_q <= run_flag;
            idx_cnt_q  <= idx_cnt_d;
            pre_cnt_q  <= pre_cnt_d;
            post_cnt_q <= post_cnt_d;
            pre_len_q  <= pre_len_d;
            tot_len_q  <= tot_len_d;
            sts_q      <= sts_d;
        end
    end

    // NOTE: every variable gets a default first, so no path through the case infers a latch.
    always_comb begin
        state_d    = state_q;
        idx_cnt_d  = idx_cnt_q;
        pre_cnt_d  = pre_cnt_q;
        post_cnt_d = post_cnt_q;
        pre_len_d  = pre_len_q;
        tot_len_d  = tot_len_q;
        sts_d      = sts_q;
        s_tready   = 1'b1;
        m_tvalid   = 1'b0;
        m_tlast    = 1'b0;
        busy_c     = 1'b0;

        if (state_q != S_IDLE) begin
            s_tready = m_axis.tready;
            m_tvalid = s_axis.tvalid;
            busy_c   = 1'b1;
            if (xfer) begin
                idx_cnt_d = idx_cnt_q + 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (arm) begin
                    idx_cnt_d = '0;
                    pre_cnt_d = '0;
                    pre_len_d = pre_data;
                    tot_len_d = tot_data;
                    state_d   = (pre_data == '0) ? S_WAIT : S_PRE;
                end
            end
            S_PRE: begin
                if (xfer) begin
                    pre_cnt_d = pre_cnt_inc;
                    if (pre_cnt_inc == pre_len_q) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                m_tlast = trg_flag & (post_len == CNTR_WIDTH'(1));
                if (xfer && trg_flag) begin
                    sts_d      = idx_cnt_q;
                    post_cnt_d = CNTR_WIDTH'(1);
                    state_d    = m_tlast ? S_IDLE : S_POST;
                end
            end
            S_POST: begin
                m_tlast = (post_cnt_q == post_len - 1'b1);
                if (xfer) begin
                    post_cnt_d = post_cnt_q + 1'b1;
                    if (m_tlast) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sample        = s_axis.tdata;
    assign m_axis.tdata  = sample;
    assign m_axis.tvalid = m_tvalid;
    assign m_axis.tlast  = m_tlast;
    assign s_axis.tready = s_tready;
    assign busy          = busy_c;
    assign sts_data      = sts_q;
endmodule

// File: tb/tb_axis_trigger_capture.sv
// Directed bench for axis_trigger_capture: one linear sequence of cycles, each with
// hand-derived expectations for the combinational outputs and the trigger position.
module tb_axis_trigger_capture;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic          run_flag;
    logic          trg_flag;
    logic [CW-1:0] pre_data;
    logic [CW-1:0] tot_data;
    logic [CW-1:0] sts_data;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;
    int sample_no   = 0;

    always #5 aclk = ~aclk;

    axis_trigger_capture_if #(.DATA_WIDTH(DW)) s_if ();
    axis_trigger_capture_if #(.DATA_WIDTH(DW)) m_if ();

    assign s_if.tlast = 1'b0;

    axis_trigger_capture #(
        .AXIS_TDATA_WIDTH(DW),
        .CNTR_WIDTH      (CW)
    ) dut (
        .aclk    (aclk),
        .areset  (areset),
        .run_flag(run_flag),
        .trg_flag(trg_flag),
        .pre_data(pre_data),
        .tot_data(tot_data),
        .sts_data(sts_data),
        .busy    (busy),
        .s_axis  (s_if),
        .m_axis  (m_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, check the combinational outputs 1ns later.
    task automatic cyc(input string tag, input logic rst, input logic run, input logic v,
                       input logic trg, input logic mr, input logic e_mv, input logic e_sr,
                       input logic e_last, input logic e_busy);
        @(negedge aclk);
        areset      = rst;
        run_flag    = run;
        s_if.tvalid = v;
        trg_flag    = trg;
        m_if.tready = mr;
        s_if.tdata  = 32'hD000_0000 + 32'(sample_no);
        sample_no++;
        #1;
        check({tag, ".tvalid"}, 32'(m_if.tvalid), 32'(e_mv));
        check({tag, ".tready"}, 32'(s_if.tready), 32'(e_sr));
        check({tag, ".tlast"},  32'(m_if.tlast),  32'(e_last));
        check({tag, ".busy"},   32'(busy),        32'(e_busy));
        if (e_mv) check({tag, ".tdata"}, m_if.tdata, s_if.tdata);
    endtask

    task automatic idle_cyc(input string tag, input logic run);
        cyc(tag, 1'b0, run, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic fwd(input string tag, input logic trg, input logic last);
        cyc(tag, 1'b0, 1'b0, 1'b1, trg, 1'b1, 1'b1, 1'b1, last, 1'b1);
    endtask

    task automatic arm(input logic [CW-1:0] pre, input logic [CW-1:0] tot);
        pre_data = pre;
        tot_data = tot;
        idle_cyc("arm", 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        areset      = 1'b1;
        run_flag    = 1'b0;
        trg_flag    = 1'b0;
        pre_data    = '0;
        tot_data    = '0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b1;

        // Reset state
        cyc("rst0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("rst1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("rst.sts", 32'(sts_data), 32'd0);
        idle_cyc("idle_discard", 1'b0);

        // pre=4 tot=10, trigger on idx 6 -> tail ends with tlast on idx 11
        arm(16'd4, 16'd10);
        for (int i = 0; i < 12; i++) fwd($sformatf("t1_i%0d", i), i == 6, i == 11);
        idle_cyc("t1_done", 1'b0);
        check("t1.sts", 32'(sts_data), 32'd6);

        // Triggers in PRE ignored; first WAIT transfer (idx 4) is accepted
        arm(16'd4, 16'd10);
        for (int i = 0; i < 10; i++)
            fwd($sformatf("t2_i%0d", i), (i >= 2) && (i <= 4), i == 9);
        idle_cyc("t2_done", 1'b0);
        check("t2.sts", 32'(sts_data), 32'd4);

        // pre=0 tot=1: straight to WAIT, trigger sample carries tlast
        arm(16'd0, 16'd1);
        cyc("t3_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t3.sts_held", 32'(sts_data), 32'd4);
        fwd("t3_i0", 1'b1, 1'b1);
        idle_cyc("t3_done", 1'b0);
        check("t3.sts", 32'(sts_data), 32'd0);

        // Clamp: pre=5 tot=3 -> only the trigger sample after PRE, with tlast
        arm(16'd5, 16'd3);
        fwd("t4_i0", 1'b0, 1'b0);
        cyc("t4_gap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        fwd("t4_i1", 1'b1, 1'b0);
        for (int i = 2; i < 5; i++) fwd($sformatf("t4_i%0d", i), 1'b0, 1'b0);
        fwd("t4_i5", 1'b1, 1'b1);
        idle_cyc("t4_done", 1'b0);
        check("t4.sts", 32'(sts_data), 32'd5);

        // Back-pressure: stalled trigger ignored, POST stalled every other cycle
        arm(16'd4, 16'd10);
        for (int i = 0; i < 4; i++) fwd($sformatf("t5_i%0d", i), 1'b0, 1'b0);
        cyc("t5_wstall", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        fwd("t5_i4", 1'b0, 1'b0);
        fwd("t5_i5", 1'b0, 1'b0);
        fwd("t5_i6", 1'b1, 1'b0);
        for (int k = 7; k < 12; k++) begin
            cyc($sformatf("t5_stall%0d", k), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                1'b1, 1'b0, k == 11, 1'b1);
            cyc($sformatf("t5_i%0d", k), 1'b0, k == 11, 1'b1, 1'b0, 1'b1,
                1'b1, 1'b1, k == 11, 1'b1);
        end
        check("t5.sts", 32'(sts_data), 32'd6);
        idle_cyc("t5_ign", 1'b1);
        idle_cyc("t5_idle", 1'b0);

        // Reset mid-POST, run held through reset, restart from idx 0
        arm(16'd2, 16'd8);
        fwd("t6_i0", 1'b0, 1'b0);
        fwd("t6_i1", 1'b1, 1'b0);
        fwd("t6_i2", 1'b1, 1'b0);
        fwd("t6_i3", 1'b0, 1'b0);
        fwd("t6_i4", 1'b0, 1'b0);
        check("t6.sts", 32'(sts_data), 32'd2);
        cyc("t6_rst", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        pre_data = 16'd1;
        tot_data = 16'd3;
        idle_cyc("t6_rel", 1'b1);
        check("t6.sts_rst", 32'(sts_data), 32'd0);
        fwd("t6_n0", 1'b0, 1'b0);
        fwd("t6_n1", 1'b1, 1'b0);
        fwd("t6_n2", 1'b0, 1'b1);
        idle_cyc("t6_done", 1'b0);
        check("t6.sts_new", 32'(sts_data), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
